// File: rtl/dvsi_scan_reader.sv
// dvsi_scan_reader: row/column scan readout controller for the DVSI event sensor.
// It drives the sensor row/column clocks and resets, samples the ON/OFF lines of each
// 4-pixel column group, and packs non-empty samples into 32-bit words. The words go
// into a first-word fall-through FIFO and out on a valid/ready stream.
// Optional feature: define DVSI_FRAME_ID_EN to stamp evt_data_o[31:24] with an 8-bit
// frame counter. Without it that byte is constant zero.
module dvsi_scan_reader #(
    parameter int unsigned ROWS       = 64,
    parameter int unsigned COL_GROUPS = 16,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic        dvsi_yclk_o,
    output logic        dvsi_ynrst_o,
    output logic        dvsi_xclk_o,
    output logic        dvsi_xnrst_o,
    input  logic [3:0]  dvsi_on_i,
    input  logic [3:0]  dvsi_off_i,
    output logic [31:0] evt_data_o,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    output logic        frame_done_o,
    output logic [15:0] drop_cnt_o,
    output logic        busy_o
);

    // The phase timer spans a full clock period (high + low half).
    localparam int unsigned TW = $clog2(2 * CLK_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_HALF   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_FULL   = TW'(2 * CLK_DIV - 1);
    localparam logic [7:0]    LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0]    LAST_GRP = 8'(COL_GROUPS - 1);
    localparam logic [AW-1:0] P_ONE    = AW'(1);
    localparam logic [AW:0]   C_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   C_FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StYrst,
        StRow,
        StXrst,
        StCol,
        StEof
    } state_e;

    // Scan FSM state and registered sensor-side outputs
    state_e          r_state;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_row;
    logic [7:0]      r_grp;
    logic            r_yclk;
    logic            r_ynrst;
    logic            r_xclk;
    logic            r_xnrst;
    logic            r_frame_done;

    // Sample pipeline: word captured on the last low cycle, pushed the cycle after
    logic            r_push;
    logic [31:0]     r_push_word;

    // Input synchronisers
    logic [3:0]      r_on_meta;
    logic [3:0]      r_on_sync;
    logic [3:0]      r_off_meta;
    logic [3:0]      r_off_sync;

    // Event FIFO
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic [15:0]     r_drop_cnt;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;
    logic            w_abort;
    logic [AW-1:0]   w_last_ptr;
    logic [7:0]      w_frame_id;

`ifdef DVSI_FRAME_ID_EN
    logic [7:0]      r_frame_id;

    // Frame counter advances once per completed frame; aborted frames do not count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_frame_id <= 8'd0;
        end else if (r_state == StEof) begin
            r_frame_id <= r_frame_id + 8'd1;
        end
    end

    assign w_frame_id = r_frame_id;
`else
    assign w_frame_id = 8'h00;
`endif

    // Two-flop synchronisers for the asynchronous event lines
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_on_meta  <= 4'd0;
            r_on_sync  <= 4'd0;
            r_off_meta <= 4'd0;
            r_off_sync <= 4'd0;
        end else begin
            r_on_meta  <= dvsi_on_i;
            r_on_sync  <= r_on_meta;
            r_off_meta <= dvsi_off_i;
            r_off_sync <= r_off_meta;
        end
    end

    // Abort wins everywhere except IDLE (nothing to abort) and EOF (already finishing)
    assign w_abort = !en_i && (r_state != StIdle) && (r_state != StEof);

    // Scan FSM: phase timing, row/group counters, sensor clocks/resets, event capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_timer      <= '0;
            r_row        <= 8'd0;
            r_grp        <= 8'd0;
            r_yclk       <= 1'b0;
            r_ynrst      <= 1'b0;
            r_xclk       <= 1'b0;
            r_xnrst      <= 1'b0;
            r_frame_done <= 1'b0;
            r_push       <= 1'b0;
            r_push_word  <= 32'd0;
        end else begin
            r_frame_done <= 1'b0;
            r_push       <= 1'b0;
            if (w_abort) begin
                // Drop everything back to the sensor-in-reset idle condition
                r_state <= StIdle;
                r_timer <= '0;
                r_yclk  <= 1'b0;
                r_ynrst <= 1'b0;
                r_xclk  <= 1'b0;
                r_xnrst <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (en_i) begin
                            r_state <= StYrst;
                            r_timer <= '0;
                            r_ynrst <= 1'b0;
                            r_xnrst <= 1'b0;
                        end
                    end
                    StYrst: begin
                        if (r_timer == T_HALF) begin
                            r_state <= StRow;
                            r_timer <= '0;
                            r_ynrst <= 1'b1;
                            r_row   <= 8'd0;
                            r_yclk  <= 1'b1;
                        end else begin
                            r_timer <= r_timer + T_ONE;
                        end
                    end
                    StRow: begin
                        if (r_timer == T_HALF) begin
                            r_yclk <= 1'b0;
                        end
                        if (r_timer == T_FULL) begin
                            r_state <= StXrst;
                            r_timer <= '0;
                            r_xnrst <= 1'b0;
                        end else begin
                            r_timer <= r_timer + T_ONE;
                        end
                    end
                    StXrst: begin
                        if (r_timer == T_HALF) begin
                            r_state <= StCol;
                            r_timer <= '0;
                            r_xnrst <= 1'b1;
                            r_grp   <= 8'd0;
                            r_xclk  <= 1'b1;
                        end else begin
                            r_timer <= r_timer + T_ONE;
                        end
                    end
                    StCol: begin
                        if (r_timer == T_HALF) begin
                            r_xclk <= 1'b0;
                        end
                        if (r_timer == T_FULL) begin
                            // Last low cycle: capture the group with its own row/grp labels
                            r_timer     <= '0;
                            r_push      <= |{r_on_sync, r_off_sync};
                            r_push_word <= {w_frame_id, r_row, r_grp, r_on_sync, r_off_sync};
                            if (r_grp == LAST_GRP) begin
                                if (r_row == LAST_ROW) begin
                                    r_state      <= StEof;
                                    r_frame_done <= 1'b1;
                                    r_ynrst      <= 1'b0;
                                end else begin
                                    r_row   <= r_row + 8'd1;
                                    r_state <= StRow;
                                    r_yclk  <= 1'b1;
                                end
                            end else begin
                                r_grp  <= r_grp + 8'd1;
                                r_xclk <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer + T_ONE;
                        end
                    end
                    StEof: begin
                        r_timer <= '0;
                        if (en_i) begin
                            r_state <= StYrst;
                        end else begin
                            r_state <= StIdle;
                            r_xnrst <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // FIFO handshake decode; a pop frees the slot a simultaneous push needs when full
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == C_FULL);
        w_pop      = !w_empty && evt_ready_i;
        w_wr       = r_push && (!w_full || w_pop);
        w_drop     = r_push && w_full && !w_pop;
        w_last_ptr = r_rd_ptr - P_ONE;
    end

    // FIFO storage, pointers, occupancy and saturating drop counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= 32'd0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_push_word;
                r_wr_ptr        <= r_wr_ptr + P_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + C_ONE;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - C_ONE;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // When empty the slot behind the read pointer still holds the last popped word
    assign evt_data_o   = w_empty ? r_mem[w_last_ptr] : r_mem[r_rd_ptr];
    assign evt_valid_o  = !w_empty;
    assign drop_cnt_o   = r_drop_cnt;
    assign frame_done_o = r_frame_done;
    assign busy_o       = (r_state != StIdle);
    assign dvsi_yclk_o  = r_yclk;
    assign dvsi_ynrst_o = r_ynrst;
    assign dvsi_xclk_o  = r_xclk;
    assign dvsi_xnrst_o = r_xnrst;

endmodule

// File: tb/tb_dvsi_scan_reader.sv
// tb_dvsi_scan_reader: directed + randomized bench for dvsi_scan_reader.
// The reference model derives each frame's timing and event list from the frame arithmetic
// (phase lengths per row/group) and keeps the expected FIFO contents in a queue.
module tb_dvsi_scan_reader;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned CG    = 2;
    localparam int unsigned CD    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int ROW_LEN = 3 * CD + CG * 2 * CD;
    localparam int FRAME   = CD + ROWS * ROW_LEN + 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        dvsi_yclk_o;
    logic        dvsi_ynrst_o;
    logic        dvsi_xclk_o;
    logic        dvsi_xnrst_o;
    logic [3:0]  dvsi_on_i;
    logic [3:0]  dvsi_off_i;
    logic [31:0] evt_data_o;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic        frame_done_o;
    logic [15:0] drop_cnt_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]  pat [3][ROWS][CG];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          exp_drop = 0;
    int          fid_base = 0;
    int          ready_mode = 1;
    bit          noise_en = 0;
    logic [7:0]  idle_val = 8'h00;

    dvsi_scan_reader #(
        .ROWS       (ROWS),
        .COL_GROUPS (CG),
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .dvsi_yclk_o  (dvsi_yclk_o),
        .dvsi_ynrst_o (dvsi_ynrst_o),
        .dvsi_xclk_o  (dvsi_xclk_o),
        .dvsi_xnrst_o (dvsi_xnrst_o),
        .dvsi_on_i    (dvsi_on_i),
        .dvsi_off_i   (dvsi_off_i),
        .evt_data_o   (evt_data_o),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .frame_done_o (frame_done_o),
        .drop_cnt_o   (drop_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fid(input int f);
`ifdef DVSI_FRAME_ID_EN
        return 8'(fid_base + f);
`else
        return 8'(f * 0);
`endif
    endfunction

    function automatic void model_push(input logic [31:0] w);
        if (ready_mode == 0 && exp_q.size() >= DEPTH) begin
            if (exp_drop < 16'hFFFF) exp_drop++;
        end else begin
            exp_q.push_back(w);
        end
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_yclk"}, 32'(dvsi_yclk_o), 0);
        chk({tag, "_ynrst"}, 32'(dvsi_ynrst_o), 0);
        chk({tag, "_xclk"}, 32'(dvsi_xclk_o), 0);
        chk({tag, "_xnrst"}, 32'(dvsi_xnrst_o), 0);
        chk({tag, "_data"}, evt_data_o, 0);
        chk({tag, "_valid"}, 32'(evt_valid_o), 0);
        chk({tag, "_done"}, 32'(frame_done_o), 0);
        chk({tag, "_drop"}, 32'(drop_cnt_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    task automatic do_pop();
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk("extra_word_valid", 32'(evt_valid_o), 0);
        end else begin
            e = exp_q.pop_front();
            chk("word", evt_data_o, e);
            got_q.push_back(evt_data_o);
        end
    endtask

    // Expected sensor-side waveform at frame-relative cycle c
    task automatic chk_cycle(input int c);
        int rel;
        int rem;
        bit yrst;
        bit eof;
        yrst = (c < CD);
        eof  = (c == FRAME - 1);
        rem  = 0;
        if (!yrst && !eof) begin
            rel = c - CD;
            rem = rel % ROW_LEN;
        end
        chk("frame_done", 32'(frame_done_o), 32'(eof));
        chk("busy", 32'(busy_o), 1);
        chk("yclk", 32'(dvsi_yclk_o), 32'(!yrst && !eof && rem < CD));
        chk("xclk", 32'(dvsi_xclk_o),
            32'(!yrst && !eof && rem >= 3 * CD && ((rem - 3 * CD) % (2 * CD)) < CD));
        chk("ynrst", 32'(dvsi_ynrst_o), 32'(!yrst && !eof));
        if (!yrst && !eof && rem >= 2 * CD) chk("xnrst", 32'(dvsi_xnrst_o), 32'(rem >= 3 * CD));
    endtask

    // Pattern is held over the settled part of each group window; elsewhere noise or fill
    task automatic drive(input int f, input int c);
        logic [7:0] v;
        int rel;
        int rem;
        int g;
        int off;
        v = noise_en ? 8'($urandom) : idle_val;
        if (c >= CD && c < FRAME - 1) begin
            rel = c - CD;
            rem = rel % ROW_LEN;
            if (rem >= 3 * CD) begin
                g   = (rem - 3 * CD) / (2 * CD);
                off = (rem - 3 * CD) % (2 * CD);
                if (off >= 2) v = pat[f][rel / ROW_LEN][g];
            end
        end
        {dvsi_on_i, dvsi_off_i} = v;
    endtask

    // stop_kind: 0 run nf frames, 1 abort (en_i=0) at stop_at, 2 reset at stop_at
    task automatic run(input int nf, input int stop_at, input int stop_kind);
        int s;
        int f;
        int c;
        bit stopped;
        for (int fi = 0; fi < nf; fi++)
            for (int r = 0; r < ROWS; r++)
                for (int g = 0; g < CG; g++) begin
                    s = fi * FRAME + CD + r * ROW_LEN + 3 * CD + g * 2 * CD + 2 * CD - 1;
                    if ((stop_kind == 0 || s < stop_at) && pat[fi][r][g] != 8'h00)
                        model_push({fid(fi), 8'(r), 8'(g), pat[fi][r][g]});
                end
        stopped = 0;
        en_i = 1'b1;
        for (int cyc = 0; !stopped && cyc < 5000; cyc++) begin
            @(posedge clk_i);
            #1;
            f = cyc / FRAME;
            c = cyc % FRAME;
            chk_cycle(c);
            drive(f, c);
            case (ready_mode)
                0: evt_ready_i = 1'b0;
                1: evt_ready_i = 1'b1;
                default: evt_ready_i = (cyc % 4 == 3) ? 1'b1 : 1'($urandom);
            endcase
            if (evt_valid_o && evt_ready_i) do_pop();
            if (stop_kind == 1 && cyc == stop_at) begin
                en_i = 1'b0;
                @(posedge clk_i);
                #1;
                evt_ready_i = 1'b0;
                chk("abort_busy", 32'(busy_o), 0);
                chk("abort_yclk", 32'(dvsi_yclk_o), 0);
                chk("abort_xclk", 32'(dvsi_xclk_o), 0);
                chk("abort_ynrst", 32'(dvsi_ynrst_o), 0);
                chk("abort_xnrst", 32'(dvsi_xnrst_o), 0);
                chk("abort_valid", 32'(evt_valid_o), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) chk("abort_head", evt_data_o, exp_q[0]);
                chk("abort_drop", 32'(drop_cnt_o), 32'(exp_drop));
                repeat (5) @(posedge clk_i);
                #1;
                chk("abort_hold_busy", 32'(busy_o), 0);
                chk("abort_hold_valid", 32'(evt_valid_o), 32'(exp_q.size() != 0));
                fid_base += stop_at / FRAME;
                stopped = 1;
            end else if (stop_kind == 2 && cyc == stop_at) begin
                evt_ready_i = 1'b0;
                chk("pre_rst_valid", 32'(evt_valid_o), 1);
                chk("pre_rst_count", 32'(exp_q.size()), 3);
                #2;
                rst_i = 1'b1;
                en_i  = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                exp_q.delete();
                exp_drop = 0;
                fid_base = 0;
                @(posedge clk_i);
                #1;
                rst_i = 1'b0;
                stopped = 1;
            end else if (stop_kind == 0 && f == nf - 1 && c == FRAME - 1) begin
                en_i = 1'b0;
                @(posedge clk_i);
                #1;
                chk("end_busy", 32'(busy_o), 0);
                chk("end_done", 32'(frame_done_o), 0);
                fid_base += nf;
                stopped = 1;
            end
        end
        chk("run_finished", 32'(stopped), 1);
        evt_ready_i = 1'b0;
    endtask

    task automatic drain();
        evt_ready_i = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || evt_valid_o); i++) begin
            if (evt_valid_o) do_pop();
            @(posedge clk_i);
            #1;
        end
        evt_ready_i = 1'b0;
        chk("drain_valid", 32'(evt_valid_o), 0);
        chk("drain_missing", 32'(exp_q.size()), 0);
    endtask

    task automatic set_pat(input int mode, input logic [7:0] v);
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < ROWS; r++)
                for (int g = 0; g < CG; g++)
                    case (mode)
                        0: pat[f][r][g] = v;
                        1: pat[f][r][g] = 8'($urandom_range(1, 255));
                        default: pat[f][r][g] = ($urandom % 2 == 0) ? 8'h00 : 8'($urandom);
                    endcase
    endtask

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b0;
        dvsi_on_i   = 4'h0;
        dvsi_off_i  = 4'h0;
        evt_ready_i = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("idle_busy", 32'(busy_o), 0);

        // Quiet sensor: only frame timing, no words
        set_pat(0, 8'h00);
        noise_en   = 0;
        idle_val   = 8'h00;
        ready_mode = 1;
        run(2, 0, 0);
        chk("quiet_valid", 32'(evt_valid_o), 0);
        drain();

        // Every pixel ON, consumer stalled: FIFO fills, the rest are dropped
        set_pat(0, 8'hF0);
        idle_val   = 8'hF0;
        ready_mode = 0;
        run(2, 0, 0);
        chk("full_drop", 32'(drop_cnt_o), 32'(exp_drop));
        chk("full_valid", 32'(evt_valid_o), 1);
        idle_val = 8'h00;
        drain();
        chk("drop_kept", 32'(drop_cnt_o), 32'(exp_drop));

        // Reset mid-frame with three words buffered
        set_pat(0, 8'h00);
        pat[0][0][0] = 8'h81;
        pat[0][0][1] = 8'h42;
        pat[0][1][0] = 8'h18;
        noise_en   = 1;
        ready_mode = 0;
        run(1, 60, 2);
        chk("post_rst_busy", 32'(busy_o), 0);

        // Single event at row 2 group 1 in two consecutive frames
        set_pat(0, 8'h00);
        pat[0][2][1] = 8'h50;
        pat[1][2][1] = 8'h50;
        ready_mode = 1;
        got_q.delete();
        run(2, 0, 0);
        drain();
        chk("single_count", 32'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            chk("single_word0", got_q[0], 32'h0002_0150);
`ifdef DVSI_FRAME_ID_EN
            chk("single_word1", got_q[1], 32'h0102_0150);
`else
            chk("single_word1", got_q[1], 32'h0002_0150);
`endif
        end

        // Abort in the middle of row 1 group 0 with a stalled consumer
        set_pat(1, 8'h00);
        ready_mode = 0;
        run(1, CD + ROW_LEN + 3 * CD + CD, 1);
        drain();

        // Random events, random back-pressure, frame id must not have moved on abort
        set_pat(2, 8'h00);
        ready_mode = 2;
        run(2, 0, 0);
        drain();
        chk("rand_drop", 32'(drop_cnt_o), 32'(exp_drop));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
